// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result plus carry/overflow for every non-multiply opcode.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res_c,
  output logic             cflag_c,
  output logic             vflag_c,
  output logic             illegal_c
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             add_v;
  logic             sub_v;
  logic             slt_bit;
  logic             sltu_bit;

  // Shared WIDTH+1 adders; subtraction is x + ~y + 1 so diff[WIDTH] is NOT borrow.
  assign sum      = {1'b0, x} + {1'b0, y};
  assign diff     = {1'b0, x} + {1'b0, ~y} + W1'(1);
  assign shamt    = y[SHW-1:0];
  assign add_v    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  assign sub_v    = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
  assign slt_bit  = diff[WIDTH-1] ^ sub_v;
  assign sltu_bit = ~diff[WIDTH];

  // Opcode decode; every path fully assigns the result so nothing propagates X.
  always_comb begin
    res_c     = '0;
    cflag_c   = 1'b0;
    vflag_c   = 1'b0;
    illegal_c = 1'b0;
    case (op)
      OP_AND:  res_c = x & y;
      OP_OR:   res_c = x | y;
      OP_ADD: begin
        res_c   = sum[WIDTH-1:0];
        cflag_c = sum[WIDTH];
        vflag_c = add_v;
      end
      OP_SLL:  res_c = x << shamt;
      OP_SRL:  res_c = x >> shamt;
      OP_SRA:  res_c = $unsigned($signed(x) >>> shamt);
      OP_SUB: begin
        res_c   = diff[WIDTH-1:0];
        cflag_c = diff[WIDTH];
        vflag_c = sub_v;
      end
      OP_SLT:  res_c = WIDTH'(slt_bit);
      OP_SLTU: res_c = WIDTH'(sltu_bit);
      OP_XOR:  res_c = x ^ y;
      OP_MUL:  illegal_c = !MUL_EN;
      OP_NOR:  res_c = ~(x | y);
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             Zflag,
  output logic             Cflag,
  output logic             Vflag,
  output logic             Nflag,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             is_mul;
  logic             load_op;
  logic             start_mul;
  logic             load_mul;
  logic             mul_last;
  logic             in_mul;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] acc_nxt;
  logic             cflag_c;
  logic             vflag_c;
  logic             illegal_c;

  alu_comb #(
    .WIDTH  (WIDTH),
    .MUL_EN (MUL_EN)
  ) u_comb (
    .x         (X),
    .y         (Y),
    .op        (S),
    .res_c     (res_c),
    .cflag_c   (cflag_c),
    .vflag_c   (vflag_c),
    .illegal_c (illegal_c)
  );

  assign is_mul    = MUL_EN && (S == OP_MUL);
  assign in_mul    = (state == MUL);
  assign out_valid = (state == DONE);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and datapath-load decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_op   = 1'b0;
    start_mul = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      MUL: begin
        if (mul_last) begin
          load_mul  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (in_ready && in_valid) begin
      if (is_mul) begin
        start_mul = 1'b1;
        state_nxt = MUL;
      end else begin
        load_op   = 1'b1;
        state_nxt = DONE;
      end
    end else if ((state == DONE) && out_ready) begin
      state_nxt = IDLE;
    end
  end

  // Result and flag registers: only written on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r       <= '0;
      Zflag   <= 1'b0;
      Cflag   <= 1'b0;
      Vflag   <= 1'b0;
      Nflag   <= 1'b0;
      illegal <= 1'b0;
    end else if (load_op) begin
      r       <= res_c;
      Zflag   <= (res_c == '0);
      Cflag   <= cflag_c;
      Vflag   <= vflag_c;
      Nflag   <= res_c[WIDTH-1];
      illegal <= illegal_c;
    end else if (load_mul) begin
      r       <= acc_nxt;
      Zflag   <= (acc_nxt == '0);
      Cflag   <= 1'b0;
      Vflag   <= 1'b0;
      Nflag   <= acc_nxt[WIDTH-1];
      illegal <= 1'b0;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      logic [WIDTH-1:0] mcand;
      logic [WIDTH-1:0] mplier;
      logic [WIDTH-1:0] acc;
      logic [CW-1:0]    cnt;

      assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
      assign mul_last = (cnt == CW'(WIDTH - 1));

      // One multiplier bit per cycle: add shifted multiplicand when the bit is set.
      always_ff @(posedge clk) begin
        if (rst) begin
          mcand  <= '0;
          mplier <= '0;
          acc    <= '0;
          cnt    <= '0;
        end else if (start_mul) begin
          mcand  <= X;
          mplier <= Y;
          acc    <= '0;
          cnt    <= '0;
        end else if (in_mul) begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_nxt;
          cnt    <= cnt + CW'(1);
        end
      end
    end else begin : g_nomul
      assign acc_nxt  = '0;
      assign mul_last = 1'b1;
    end
  endgenerate

endmodule
